reservation_station: RTL and testbench

- Receives RS-bound instructions issued by the decoder: LUI, AUIPC, JAL, JALR, B_TYPE, I_TYPE, R_TYPE. LD_TYPE/S_TYPE go to the LSB and are ignored here.
- Holds each instruction until both source operands are resolved, snooping the ALU and LSB common data buses for missing operands.
- Dispatches one ready instruction per cycle to the ALU.
- Drives `rs_full` back to the decoder, with lookahead for the decoder's one-cycle registered issue.

---
 rtl/reservation_station_if.sv | 60 ++++++
 rtl/reservation_station.sv | 192 +++++++++++++++++++
 tb/tb_reservation_station.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reservation_station_if.sv
// Issue, common-data-bus and ALU-dispatch signals of the reservation station,
// grouped so the decoder/CDB side and the station side share one bundle.
interface reservation_station_if #(
    parameter int ROB_W = 4
);
    logic             issue_valid;
    logic [31:0]      issue_instr;
    logic [6:0]       issue_type;
    logic [2:0]       issue_op;
    logic [31:0]      issue_pc;
    logic [31:0]      issue_imm;
    logic [31:0]      issue_val1;
    logic [31:0]      issue_val2;
    logic             issue_dep1;
    logic             issue_dep2;
    logic [ROB_W-1:0] issue_tag1;
    logic [ROB_W-1:0] issue_tag2;
    logic [ROB_W-1:0] issue_rob_id;

    logic             cdb_alu_valid;
    logic [ROB_W-1:0] cdb_alu_tag;
    logic [31:0]      cdb_alu_value;
    logic             cdb_lsb_valid;
    logic [ROB_W-1:0] cdb_lsb_tag;
    logic [31:0]      cdb_lsb_value;

    logic             rs_full;

    logic             alu_valid;
    logic [6:0]       alu_type;
    logic [2:0]       alu_op;
    logic             alu_f7;
    logic [31:0]      alu_val1;
    logic [31:0]      alu_val2;
    logic [31:0]      alu_pc;
    logic [31:0]      alu_imm;
    logic [ROB_W-1:0] alu_rob_id;

    modport master (
        output issue_valid, issue_instr, issue_type, issue_op, issue_pc, issue_imm,
               issue_val1, issue_val2, issue_dep1, issue_dep2, issue_tag1, issue_tag2,
               issue_rob_id,
               cdb_alu_valid, cdb_alu_tag, cdb_alu_value,
               cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_value,
        input  rs_full,
               alu_valid, alu_type, alu_op, alu_f7, alu_val1, alu_val2, alu_pc,
               alu_imm, alu_rob_id
    );

    modport slave (
        input  issue_valid, issue_instr, issue_type, issue_op, issue_pc, issue_imm,
               issue_val1, issue_val2, issue_dep1, issue_dep2, issue_tag1, issue_tag2,
               issue_rob_id,
               cdb_alu_valid, cdb_alu_tag, cdb_alu_value,
               cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_value,
        output rs_full,
               alu_valid, alu_type, alu_op, alu_f7, alu_val1, alu_val2, alu_pc,
               alu_imm, alu_rob_id
    );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: buffers ALU-bound instructions until both operands are
// known, snoops the ALU and LSB result buses, and dispatches one ready entry
// per cycle (lowest index first). rs_full looks one issue ahead because the
// decoder registers its issue a cycle after sampling it.
module reservation_station #(
    parameter int RS_SIZE  = 8,
    parameter int RS_IDX_W = 3,
    parameter int ROB_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic rob_clear,
    reservation_station_if.slave bus
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [RS_IDX_W+1:0] FULL_MARK = (RS_IDX_W+2)'(RS_SIZE);

    typedef struct packed {
        logic [6:0]       kind;
        logic [2:0]       op;
        logic             f7;
        logic [31:0]      val1;
        logic [31:0]      val2;
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic             dep1;
        logic             dep2;
        logic [ROB_W-1:0] tag1;
        logic [ROB_W-1:0] tag2;
        logic [ROB_W-1:0] rob_id;
    } entry_t;

    entry_t                entries [RS_SIZE];
    logic [RS_SIZE-1:0]    busy;
    logic [RS_IDX_W:0]     occupied;

    logic                  rs_bound;
    logic                  accept;
    logic [RS_SIZE-1:0]    ready;
    logic                  disp_found;
    logic [RS_IDX_W-1:0]   disp_idx;
    logic [RS_SIZE-1:0]    free_post;
    logic                  alloc_found;
    logic [RS_IDX_W-1:0]   alloc_idx;
    entry_t                incoming;
    logic                  unused_instr_bits;

    assign unused_instr_bits = ^{bus.issue_instr[31], bus.issue_instr[29:0]};

    // Only ALU-class opcodes belong here; loads and stores go to the LSB.
    always_comb begin
        case (bus.issue_type)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_B, OP_I, OP_R: rs_bound = 1'b1;
            default:                                             rs_bound = 1'b0;
        endcase
    end

    assign accept      = bus.issue_valid && rs_bound;
    assign bus.rs_full = ({1'b0, occupied} + (RS_IDX_W+2)'(accept)) >= FULL_MARK;

    // Pick the lowest-index ready entry, then the lowest free slot once that
    // dispatch is accounted for, so a freed slot is reusable at the same edge.
    always_comb begin
        ready       = '0;
        disp_found  = 1'b0;
        disp_idx    = '0;
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            ready[i] = busy[i] && !entries[i].dep1 && !entries[i].dep2;
            if (ready[i]) begin
                disp_found = 1'b1;
                disp_idx   = RS_IDX_W'(i);
            end
        end
        free_post = ~busy;
        if (disp_found) free_post[disp_idx] = 1'b1;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (free_post[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = RS_IDX_W'(i);
            end
        end
    end

    // Build the entry to be written, capturing any operand broadcast this very
    // cycle so it never waits for a result already gone past (ALU bus first).
    always_comb begin
        incoming.kind   = bus.issue_type;
        incoming.op     = bus.issue_op;
        incoming.f7     = bus.issue_instr[30];
        incoming.pc     = bus.issue_pc;
        incoming.imm    = bus.issue_imm;
        incoming.tag1   = bus.issue_tag1;
        incoming.tag2   = bus.issue_tag2;
        incoming.rob_id = bus.issue_rob_id;
        incoming.val1   = bus.issue_val1;
        incoming.dep1   = bus.issue_dep1;
        incoming.val2   = bus.issue_val2;
        incoming.dep2   = bus.issue_dep2;
        if (bus.issue_dep1) begin
            if (bus.cdb_alu_valid && bus.cdb_alu_tag == bus.issue_tag1) begin
                incoming.val1 = bus.cdb_alu_value;
                incoming.dep1 = 1'b0;
            end else if (bus.cdb_lsb_valid && bus.cdb_lsb_tag == bus.issue_tag1) begin
                incoming.val1 = bus.cdb_lsb_value;
                incoming.dep1 = 1'b0;
            end
        end
        if (bus.issue_dep2) begin
            if (bus.cdb_alu_valid && bus.cdb_alu_tag == bus.issue_tag2) begin
                incoming.val2 = bus.cdb_alu_value;
                incoming.dep2 = 1'b0;
            end else if (bus.cdb_lsb_valid && bus.cdb_lsb_tag == bus.issue_tag2) begin
                incoming.val2 = bus.cdb_lsb_value;
                incoming.dep2 = 1'b0;
            end
        end
    end

    // Entry storage, CDB wakeup, dispatch register and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy           <= '0;
            occupied       <= '0;
            bus.alu_valid  <= 1'b0;
            bus.alu_type   <= '0;
            bus.alu_op     <= '0;
            bus.alu_f7     <= 1'b0;
            bus.alu_val1   <= '0;
            bus.alu_val2   <= '0;
            bus.alu_pc     <= '0;
            bus.alu_imm    <= '0;
            bus.alu_rob_id <= '0;
            for (int i = 0; i < RS_SIZE; i++) entries[i] <= '0;
        end else if (rdy) begin
            if (rob_clear) begin
                busy          <= '0;
                occupied      <= '0;
                bus.alu_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && entries[i].dep1) begin
                        if (bus.cdb_alu_valid && bus.cdb_alu_tag == entries[i].tag1) begin
                            entries[i].val1 <= bus.cdb_alu_value;
                            entries[i].dep1 <= 1'b0;
                        end else if (bus.cdb_lsb_valid && bus.cdb_lsb_tag == entries[i].tag1) begin
                            entries[i].val1 <= bus.cdb_lsb_value;
                            entries[i].dep1 <= 1'b0;
                        end
                    end
                    if (busy[i] && entries[i].dep2) begin
                        if (bus.cdb_alu_valid && bus.cdb_alu_tag == entries[i].tag2) begin
                            entries[i].val2 <= bus.cdb_alu_value;
                            entries[i].dep2 <= 1'b0;
                        end else if (bus.cdb_lsb_valid && bus.cdb_lsb_tag == entries[i].tag2) begin
                            entries[i].val2 <= bus.cdb_lsb_value;
                            entries[i].dep2 <= 1'b0;
                        end
                    end
                end
                if (disp_found) begin
                    busy[disp_idx] <= 1'b0;
                    bus.alu_valid  <= 1'b1;
                    bus.alu_type   <= entries[disp_idx].kind;
                    bus.alu_op     <= entries[disp_idx].op;
                    bus.alu_f7     <= entries[disp_idx].f7;
                    bus.alu_val1   <= entries[disp_idx].val1;
                    bus.alu_val2   <= entries[disp_idx].val2;
                    bus.alu_pc     <= entries[disp_idx].pc;
                    bus.alu_imm    <= entries[disp_idx].imm;
                    bus.alu_rob_id <= entries[disp_idx].rob_id;
                end else begin
                    bus.alu_valid <= 1'b0;
                end
                if (accept && alloc_found) begin
                    entries[alloc_idx] <= incoming;
                    busy[alloc_idx]    <= 1'b1;
                end
                occupied <= occupied + (RS_IDX_W+1)'(accept && alloc_found)
                                     - (RS_IDX_W+1)'(disp_found);
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: stimulus pushes the dispatch it
// expects into a queue, and a negedge monitor pops and compares every dispatch.
module tb_reservation_station;
    localparam logic [6:0] T_LUI   = 7'b0110111;
    localparam logic [6:0] T_AUIPC = 7'b0010111;
    localparam logic [6:0] T_JAL   = 7'b1101111;
    localparam logic [6:0] T_JALR  = 7'b1100111;
    localparam logic [6:0] T_B     = 7'b1100011;
    localparam logic [6:0] T_I     = 7'b0010011;
    localparam logic [6:0] T_R     = 7'b0110011;
    localparam logic [6:0] T_LD    = 7'b0000011;

    typedef struct packed {
        logic [6:0]  kind;
        logic [2:0]  op;
        logic        f7;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  rob;
    } disp_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  rdy;
    logic  rob_clear;
    logic  edge_live = 1'b0;
    disp_t expq [$];
    disp_t got;
    disp_t want;
    int    vectors = 0;
    int    miscompares = 0;

    reservation_station_if #(.ROB_W(4)) bus ();

    reservation_station #(.RS_SIZE(8), .RS_IDX_W(3), .ROB_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .rob_clear (rob_clear),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Remember whether the last edge was a live one so frozen cycles are not re-counted.
    always @(posedge clk) edge_live = !rst && rdy;

    // Monitor: every fresh dispatch must match the oldest queued expectation.
    always @(negedge clk) begin
        if (edge_live && bus.alu_valid) begin
            got.kind = bus.alu_type;
            got.op   = bus.alu_op;
            got.f7   = bus.alu_f7;
            got.val1 = bus.alu_val1;
            got.val2 = bus.alu_val2;
            got.pc   = bus.alu_pc;
            got.imm  = bus.alu_imm;
            got.rob  = bus.alu_rob_id;
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL dispatch_unexpected: got %h, expected no dispatch", got);
            end else begin
                want = expq.pop_front();
                if (got !== want) begin
                    miscompares++;
                    $display("[TB] FAIL dispatch: got %h expected %h", got, want);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] kind, input logic [2:0] op, input logic f7,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] v1, input logic [31:0] v2,
                                 input logic d1, input logic d2,
                                 input logic [3:0] t1, input logic [3:0] t2, input logic [3:0] rob);
        bus.issue_valid  = 1'b1;
        bus.issue_type   = kind;
        bus.issue_op     = op;
        bus.issue_instr  = {1'b1, f7, 30'h15};
        bus.issue_pc     = pc;
        bus.issue_imm    = imm;
        bus.issue_val1   = v1;
        bus.issue_val2   = v2;
        bus.issue_dep1   = d1;
        bus.issue_dep2   = d2;
        bus.issue_tag1   = t1;
        bus.issue_tag2   = t2;
        bus.issue_rob_id = rob;
    endtask

    task automatic idleIssue();
        bus.issue_valid = 1'b0;
    endtask

    task automatic setCdb(input logic av, input logic [3:0] at, input logic [31:0] aval,
                          input logic lv, input logic [3:0] lt, input logic [31:0] lval);
        bus.cdb_alu_valid = av;
        bus.cdb_alu_tag   = at;
        bus.cdb_alu_value = aval;
        bus.cdb_lsb_valid = lv;
        bus.cdb_lsb_tag   = lt;
        bus.cdb_lsb_value = lval;
    endtask

    task automatic expectDispatch(input logic [6:0] kind, input logic [2:0] op, input logic f7,
                                  input logic [31:0] v1, input logic [31:0] v2,
                                  input logic [31:0] pc, input logic [31:0] imm,
                                  input logic [3:0] rob);
        disp_t e;
        e.kind = kind; e.op = op; e.f7 = f7; e.val1 = v1; e.val2 = v2;
        e.pc = pc; e.imm = imm; e.rob = rob;
        expq.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0;
        bus.issue_valid = 1'b0; bus.issue_instr = '0; bus.issue_type = '0; bus.issue_op = '0;
        bus.issue_pc = '0; bus.issue_imm = '0; bus.issue_val1 = '0; bus.issue_val2 = '0;
        bus.issue_dep1 = 1'b0; bus.issue_dep2 = 1'b0; bus.issue_tag1 = '0; bus.issue_tag2 = '0;
        bus.issue_rob_id = '0;
        setCdb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);

        // Reset state
        tick(); tick();
        checkOutput("rst_alu_valid", 32'(bus.alu_valid), 32'd0);
        checkOutput("rst_alu_val1", bus.alu_val1, 32'd0);
        checkOutput("rst_alu_rob_id", 32'(bus.alu_rob_id), 32'd0);
        checkOutput("rst_rs_full", 32'(bus.rs_full), 32'd0);
        rst = 1'b0;

        // Independent ADDI: dispatched one edge after being accepted
        applyStimulus(T_I, 3'd0, 1'b0, 32'h100, 32'd7, 32'd5, 32'd7, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3);
        expectDispatch(T_I, 3'd0, 1'b0, 32'd5, 32'd7, 32'h100, 32'd7, 4'd3);
        tick(); idleIssue();
        checkOutput("t1_not_yet", 32'(bus.alu_valid), 32'd0);
        tick();
        checkOutput("t1_valid", 32'(bus.alu_valid), 32'd1);
        checkOutput("t1_rob_id", 32'(bus.alu_rob_id), 32'd3);
        tick();
        checkOutput("t1_valid_drop", 32'(bus.alu_valid), 32'd0);

        // SUB waiting on tag 2, woken by the ALU bus
        applyStimulus(T_R, 3'd0, 1'b1, 32'h104, 32'd0, 32'hDEAD, 32'd9, 1'b1, 1'b0, 4'd2, 4'd0, 4'd4);
        expectDispatch(T_R, 3'd0, 1'b1, 32'h1234, 32'd9, 32'h104, 32'd0, 4'd4);
        tick(); idleIssue();
        tick();
        checkOutput("t2_blocked", 32'(bus.alu_valid), 32'd0);
        setCdb(1'b1, 4'd2, 32'h1234, 1'b0, 4'd0, 32'h0);
        tick();
        setCdb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        checkOutput("t2_wake_edge", 32'(bus.alu_valid), 32'd0);
        tick();
        checkOutput("t2_valid", 32'(bus.alu_valid), 32'd1);
        checkOutput("t2_val1", bus.alu_val1, 32'h1234);

        // Issue-time bypass from LSB bus, then a double match where the ALU bus wins
        applyStimulus(T_B, 3'd1, 1'b0, 32'h108, 32'h10, 32'h11, 32'hBAD, 1'b0, 1'b1, 4'd0, 4'd5, 4'd5);
        setCdb(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 32'hAA);
        expectDispatch(T_B, 3'd1, 1'b0, 32'h11, 32'hAA, 32'h108, 32'h10, 4'd5);
        tick();
        applyStimulus(T_I, 3'd4, 1'b0, 32'h10C, 32'h3, 32'hBAD, 32'h3, 1'b1, 1'b0, 4'd7, 4'd0, 4'd6);
        setCdb(1'b1, 4'd7, 32'h77, 1'b1, 4'd7, 32'h88);
        expectDispatch(T_I, 3'd4, 1'b0, 32'h77, 32'h3, 32'h10C, 32'h3, 4'd6);
        tick();
        idleIssue();
        setCdb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        checkOutput("t3_bypass_valid", 32'(bus.alu_valid), 32'd1);
        checkOutput("t3_bypass_val2", bus.alu_val2, 32'hAA);
        tick();
        checkOutput("t3_alu_wins_val1", bus.alu_val1, 32'h77);
        tick();
        checkOutput("t3_idle", 32'(bus.alu_valid), 32'd0);

        // Fill to capacity, all waiting on tag 6; loads must not count
        for (int i = 0; i < 7; i++) begin
            applyStimulus(T_I, 3'd0, 1'b0, 32'h200 + 32'(4*i), 32'(i), 32'hBAD, 32'(i),
                          1'b1, 1'b0, 4'd6, 4'd0, 4'(8 + i));
            expectDispatch(T_I, 3'd0, 1'b0, 32'h600, 32'(i), 32'h200 + 32'(4*i), 32'(i), 4'(8 + i));
            #1;
            checkOutput("t4_not_full", 32'(bus.rs_full), 32'd0);
            tick();
        end
        applyStimulus(T_LD, 3'd2, 1'b0, 32'h300, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        #1;
        checkOutput("t4_load_ignored", 32'(bus.rs_full), 32'd0);
        tick();
        applyStimulus(T_R, 3'd7, 1'b0, 32'h21C, 32'd0, 32'hBAD, 32'h77, 1'b1, 1'b0, 4'd6, 4'd0, 4'd15);
        expectDispatch(T_R, 3'd7, 1'b0, 32'h600, 32'h77, 32'h21C, 32'd0, 4'd15);
        #1;
        checkOutput("t4_lookahead", 32'(bus.rs_full), 32'd1);
        tick();
        idleIssue();
        #1;
        checkOutput("t4_full", 32'(bus.rs_full), 32'd1);
        setCdb(1'b1, 4'd6, 32'h600, 1'b0, 4'd0, 32'h0);
        tick();
        setCdb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        checkOutput("t4_wake_edge", 32'(bus.alu_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput("t4_drain_rob", 32'(bus.alu_rob_id), 32'(8 + k));
            if (k == 0) checkOutput("t4_full_drop", 32'(bus.rs_full), 32'd0);
        end
        tick();
        checkOutput("t4_drained", 32'(bus.alu_valid), 32'd0);

        // Flush with four waiting entries and a same-cycle issue and broadcast
        for (int i = 0; i < 4; i++) begin
            applyStimulus(T_I, 3'd0, 1'b0, 32'h300 + 32'(4*i), 32'd0, 32'd0, 32'd1,
                          1'b1, 1'b0, 4'd9, 4'd0, 4'(i));
            tick();
        end
        applyStimulus(T_I, 3'd0, 1'b0, 32'h310, 32'd0, 32'd1, 32'd1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd4);
        setCdb(1'b1, 4'd9, 32'h900, 1'b0, 4'd0, 32'h0);
        rob_clear = 1'b1;
        tick();
        rob_clear = 1'b0;
        idleIssue();
        setCdb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        checkOutput("t5_valid", 32'(bus.alu_valid), 32'd0);
        checkOutput("t5_rs_full", 32'(bus.rs_full), 32'd0);
        checkOutput("t5_occupied", 32'(dut.occupied), 32'd0);
        setCdb(1'b1, 4'd9, 32'h900, 1'b0, 4'd0, 32'h0);
        tick();
        setCdb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("t5_no_dispatch", 32'(bus.alu_valid), 32'd0);
        end

        // Freeze while an entry is ready; issue, flush and CDB are all ignored
        applyStimulus(T_JAL, 3'd0, 1'b0, 32'h400, 32'h20, 32'h400, 32'h20, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1);
        expectDispatch(T_JAL, 3'd0, 1'b0, 32'h400, 32'h20, 32'h400, 32'h20, 4'd1);
        tick();
        applyStimulus(T_LUI, 3'd0, 1'b0, 32'h404, 32'h12345000, 32'd0, 32'h12345000,
                      1'b0, 1'b0, 4'd0, 4'd0, 4'd2);
        expectDispatch(T_LUI, 3'd0, 1'b0, 32'd0, 32'h12345000, 32'h404, 32'h12345000, 4'd2);
        tick();
        checkOutput("t6_first", 32'(bus.alu_rob_id), 32'd1);
        applyStimulus(T_AUIPC, 3'd0, 1'b0, 32'h500, 32'h0, 32'h500, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd7);
        setCdb(1'b1, 4'd3, 32'h33, 1'b0, 4'd0, 32'h0);
        rob_clear = 1'b1;
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("t6_frozen_valid", 32'(bus.alu_valid), 32'd1);
            checkOutput("t6_frozen_rob", 32'(bus.alu_rob_id), 32'd1);
            checkOutput("t6_frozen_occupied", 32'(dut.occupied), 32'd1);
        end
        rdy = 1'b1;
        rob_clear = 1'b0;
        idleIssue();
        setCdb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        tick();
        checkOutput("t6_resume_rob", 32'(bus.alu_rob_id), 32'd2);
        tick();
        checkOutput("t6_idle", 32'(bus.alu_valid), 32'd0);
        tick();

        checkOutput("queue_drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
